// File: rtl/comp_refill_ctrl_if.sv
// Bundle of fetch, cache-fill, memory and dictionary-lookup signals for comp_refill_ctrl.
// master = refill controller, slave = surrounding fetch path / caches / memory / dictionaries.
interface comp_refill_ctrl_if #(
    parameter int NUM_BLOCKS = 4,
    parameter int KEY_W      = 16
);
    // Memory handshake: a read beat completes on a cycle where mem_req_valid and
    // mem_req_ready are both high; mem_req_rdata belongs to mem_req_addr that cycle.
    // While valid & ~ready the controller holds mem_req_addr and keeps valid high.
    logic                        proc_valid;
    logic [31:0]                 proc_addr;
    logic                        ic_miss;
    logic                        cc_miss;
    logic                        ic_fill_valid;
    logic [32*NUM_BLOCKS-1:0]    ic_fill_data;
    logic                        cc_fill_valid;
    logic [KEY_W*NUM_BLOCKS-1:0] cc_fill_data;
    logic                        mem_req_valid;
    logic                        mem_req_ready;
    logic [31:0]                 mem_req_addr;
    logic [31:0]                 mem_req_rdata;
    logic [31:0]                 look_word;
    logic                        look_hit;
    logic [KEY_W-1:0]            look_key;
    logic                        busy;
    logic [1:0]                  dbg_state;

    modport master (
        input  proc_valid, proc_addr, ic_miss, cc_miss,
        input  mem_req_ready, mem_req_rdata, look_hit, look_key,
        output ic_fill_valid, ic_fill_data, cc_fill_valid, cc_fill_data,
        output mem_req_valid, mem_req_addr, look_word, busy, dbg_state
    );

    modport slave (
        output proc_valid, proc_addr, ic_miss, cc_miss,
        output mem_req_ready, mem_req_rdata, look_hit, look_key,
        input  ic_fill_valid, ic_fill_data, cc_fill_valid, cc_fill_data,
        input  mem_req_valid, mem_req_addr, look_word, busy, dbg_state
    );
endinterface

// File: rtl/comp_refill_ctrl.sv
// Critical-word-first line refill engine feeding the compressed or uncompressed cache.
// Optional saturating refill statistics are enabled with `define COMP_REFILL_STATS_EN.
module comp_refill_ctrl #(
    parameter int NUM_BLOCKS = 4,
    parameter int BLOCK_SIZE = 4,
    parameter int KEY_W      = 16
) (
    input  logic               clk,
    input  logic               resetn,
    comp_refill_ctrl_if.master bus
`ifdef COMP_REFILL_STATS_EN
    ,
    output logic [31:0]        stat_refills,
    output logic [31:0]        stat_comp_fills,
    output logic [31:0]        stat_mem_wait
`endif
);
    localparam int OFF     = $clog2(NUM_BLOCKS);
    localparam int BOFF    = $clog2(BLOCK_SIZE);
    localparam int BEAT_W  = OFF + 1;
    localparam int LINE_SH = OFF + BOFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                      state_q;
    logic [31:0]                 base_q;
    logic [OFF-1:0]              ptr_q;
    logic [BEAT_W-1:0]           beats_q;
    logic                        comp_ok_q;
    logic                        mem_req_valid_q;
    logic [31:0]                 mem_req_addr_q;
    logic                        ic_fill_valid_q;
    logic                        cc_fill_valid_q;
    logic [32*NUM_BLOCKS-1:0]    ic_buf_q;
    logic [KEY_W*NUM_BLOCKS-1:0] cc_buf_q;

    logic [OFF-1:0]              ptr_d;
    logic                        comp_ok_d;
    logic                        last_beat;
    logic                        start_refill;
    logic [31:0]                 base_in;
    logic [OFF-1:0]              start_in;
    logic [31:0]                 addr_start;
    logic [31:0]                 addr_next;

    always_comb begin
        start_refill = bus.proc_valid & bus.ic_miss & bus.cc_miss;
        base_in      = (bus.proc_addr >> LINE_SH) << LINE_SH;
        start_in     = OFF'(bus.proc_addr >> BOFF);
        addr_start   = base_in | (32'(start_in) << BOFF);
        ptr_d        = ptr_q + OFF'(1);
        addr_next    = base_q | (32'(ptr_d) << BOFF);
        comp_ok_d    = comp_ok_q & bus.look_hit;
        last_beat    = (beats_q == BEAT_W'(NUM_BLOCKS - 1));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= IDLE;
            base_q          <= '0;
            ptr_q           <= '0;
            beats_q         <= '0;
            comp_ok_q       <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            ic_fill_valid_q <= 1'b0;
            cc_fill_valid_q <= 1'b0;
            ic_buf_q        <= '0;
            cc_buf_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_refill) begin
                        base_q          <= base_in;
                        ptr_q           <= start_in;
                        beats_q         <= '0;
                        comp_ok_q       <= 1'b1;
                        mem_req_valid_q <= 1'b1;
                        mem_req_addr_q  <= addr_start;
                        state_q         <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.mem_req_ready) begin
                        ic_buf_q[32*int'(ptr_q) +: 32] <= bus.mem_req_rdata;
                        // Once any word misses the dictionaries the key line is abandoned.
                        if (comp_ok_q & bus.look_hit) begin
                            cc_buf_q[KEY_W*int'(ptr_q) +: KEY_W] <= bus.look_key;
                        end
                        comp_ok_q <= comp_ok_d;
                        ptr_q     <= ptr_d;
                        beats_q   <= beats_q + BEAT_W'(1);
                        if (last_beat) begin
                            mem_req_valid_q <= 1'b0;
                            ic_fill_valid_q <= ~comp_ok_d;
                            cc_fill_valid_q <= comp_ok_d;
                            state_q         <= FILL;
                        end else begin
                            mem_req_addr_q <= addr_next;
                        end
                    end
                end
                FILL: begin
                    ic_fill_valid_q <= 1'b0;
                    cc_fill_valid_q <= 1'b0;
                    state_q         <= DRAIN;
                end
                DRAIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = mem_req_addr_q;
    assign bus.ic_fill_valid = ic_fill_valid_q;
    assign bus.cc_fill_valid = cc_fill_valid_q;
    assign bus.ic_fill_data  = ic_buf_q;
    assign bus.cc_fill_data  = cc_buf_q;
    assign bus.look_word     = bus.mem_req_rdata;
    assign bus.busy          = (state_q != IDLE);
    assign bus.dbg_state     = state_q;

`ifdef COMP_REFILL_STATS_EN
    logic [31:0] stat_refills_q;
    logic [31:0] stat_comp_fills_q;
    logic [31:0] stat_mem_wait_q;

    // Counters saturate rather than wrap so long runs never report a small value.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_refills_q    <= '0;
            stat_comp_fills_q <= '0;
            stat_mem_wait_q   <= '0;
        end else begin
            if ((ic_fill_valid_q | cc_fill_valid_q) && (stat_refills_q != '1)) begin
                stat_refills_q <= stat_refills_q + 32'd1;
            end
            if (cc_fill_valid_q && (stat_comp_fills_q != '1)) begin
                stat_comp_fills_q <= stat_comp_fills_q + 32'd1;
            end
            if ((state_q == FETCH) && !bus.mem_req_ready && (stat_mem_wait_q != '1)) begin
                stat_mem_wait_q <= stat_mem_wait_q + 32'd1;
            end
        end
    end

    assign stat_refills    = stat_refills_q;
    assign stat_comp_fills = stat_comp_fills_q;
    assign stat_mem_wait   = stat_mem_wait_q;
`else
    // Statistics counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_comp_refill_ctrl.sv
// Directed bench for comp_refill_ctrl: ordering, wait states, fill selection and reset abort.
module tb_comp_refill_ctrl;
  localparam int NB = 4;
  localparam int KW = 16;

  logic clk;
  logic resetn;
  logic [15:0] key_base;
  int tests;
  int fails;
  int wait_cfg;
  int wait_cnt;
  int beat;
  int since_start;
  logic [3:0] hit_mask;
  logic [31:0] held_addr;
  logic [31:0] exp_q[$];

`ifdef COMP_REFILL_STATS_EN
  logic [31:0] stat_refills;
  logic [31:0] stat_comp_fills;
  logic [31:0] stat_mem_wait;
`endif

  comp_refill_ctrl_if #(.NUM_BLOCKS(NB), .KEY_W(KW)) dut_if ();

  comp_refill_ctrl #(.NUM_BLOCKS(NB), .BLOCK_SIZE(4), .KEY_W(KW)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(dut_if)
`ifdef COMP_REFILL_STATS_EN
    ,
    .stat_refills(stat_refills),
    .stat_comp_fills(stat_comp_fills),
    .stat_mem_wait(stat_mem_wait)
`endif
  );

  // memory returns a tagged copy of the address; keys are key_base + word index
  assign dut_if.mem_req_rdata = 32'hD000_0000 | dut_if.mem_req_addr;
  assign dut_if.look_key = key_base + 16'(dut_if.mem_req_addr[3:2]);

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory responder: runs at each negedge, checks addresses, decides ready for next edge
  task automatic respond();
    logic [31:0] exp_addr;
    if (resetn && dut_if.mem_req_valid) begin
      if (wait_cnt > 0) begin
        chk("addr_hold", dut_if.mem_req_addr, held_addr);
      end else begin
        held_addr = dut_if.mem_req_addr;
        exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("addr_order", dut_if.mem_req_addr, exp_addr);
      end
      if (wait_cnt < wait_cfg) begin
        dut_if.mem_req_ready = 1'b0;
        dut_if.look_hit = 1'b0;
        wait_cnt++;
      end else begin
        dut_if.mem_req_ready = 1'b1;
        dut_if.look_hit = (beat < NB) ? hit_mask[beat] : 1'b0;
        beat++;
        wait_cnt = 0;
      end
    end else begin
      dut_if.mem_req_ready = 1'b0;
      dut_if.look_hit = 1'b0;
      wait_cnt = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    since_start++;
    @(negedge clk);
    respond();
  endtask

  task automatic start_refill(input logic [31:0] addr, input int waits, input logic [3:0] mask,
                              input bit hold_miss);
    dut_if.proc_addr = addr;
    dut_if.proc_valid = 1'b1;
    dut_if.ic_miss = 1'b1;
    dut_if.cc_miss = 1'b1;
    wait_cfg = waits;
    hit_mask = mask;
    beat = 0;
    wait_cnt = 0;
    tick();
    since_start = 1;
    if (!hold_miss) begin
      dut_if.proc_valid = 1'b0;
      dut_if.ic_miss = 1'b0;
      dut_if.cc_miss = 1'b0;
    end
  endtask

  task automatic wait_fill(input int exp_lat, input bit exp_cc, input logic [127:0] exp_ic_data,
                           input bit chk_cc_data, input logic [63:0] exp_cc_data);
    int guard;
    guard = 0;
    while (!(dut_if.ic_fill_valid || dut_if.cc_fill_valid) && guard < 40) begin
      chk("fetch_valid", dut_if.mem_req_valid, 1);
      tick();
      guard++;
    end
    dut_if.proc_valid = 1'b0;
    dut_if.ic_miss = 1'b0;
    dut_if.cc_miss = 1'b0;
    chk("fill_latency", since_start, exp_lat);
    chk("cc_fill_valid", dut_if.cc_fill_valid, exp_cc);
    chk("ic_fill_valid", dut_if.ic_fill_valid, !exp_cc);
    chk("fill_req_valid", dut_if.mem_req_valid, 0);
    chk("ic_fill_data", dut_if.ic_fill_data, exp_ic_data);
    if (chk_cc_data) chk("cc_fill_data", dut_if.cc_fill_data, exp_cc_data);
    chk("addr_all_used", exp_q.size(), 0);
    tick();
    chk("drain_pulse", {dut_if.ic_fill_valid, dut_if.cc_fill_valid}, 0);
    chk("drain_busy", dut_if.busy, 1);
    tick();
    chk("idle_busy", dut_if.busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tests = 0;
    fails = 0;
    wait_cfg = 0;
    wait_cnt = 0;
    beat = 0;
    since_start = 0;
    hit_mask = 4'h0;
    held_addr = 32'h0;
    key_base = 16'h0010;
    resetn = 1'b0;
    dut_if.proc_valid = 1'b0;
    dut_if.proc_addr = 32'h0;
    dut_if.ic_miss = 1'b0;
    dut_if.cc_miss = 1'b0;
    dut_if.mem_req_ready = 1'b0;
    dut_if.look_hit = 1'b0;
    @(negedge clk);
    tick();
    tick();
    chk("rst_req_valid", dut_if.mem_req_valid, 0);
    chk("rst_req_addr", dut_if.mem_req_addr, 0);
    chk("rst_fill_valid", {dut_if.ic_fill_valid, dut_if.cc_fill_valid}, 0);
    chk("rst_ic_data", dut_if.ic_fill_data, 0);
    chk("rst_cc_data", dut_if.cc_fill_data, 0);
    chk("rst_busy", dut_if.busy, 0);
    chk("rst_state", dut_if.dbg_state, 0);
    resetn = 1'b1;
    tick();

    // 1: aligned line, all hits -> compressed fill
    exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    key_base = 16'h0010;
    start_refill(32'h100, 0, 4'b1111, 0);
    chk("look_word", dut_if.look_word, 32'hD000_0100);
    wait_fill(5, 1, 128'hD000010C_D0000108_D0000104_D0000100, 1, 64'h0013_0012_0011_0010);

    // 2: critical word 3 first, wrap-around; no hits -> raw fill
    exp_q = '{32'h20C, 32'h200, 32'h204, 32'h208};
    start_refill(32'h20E, 0, 4'b0000, 0);
    wait_fill(5, 0, 128'hD000020C_D0000208_D0000204_D0000200, 0, 64'h0);

    // 3: dictionary miss on second beat only
    exp_q = '{32'h300, 32'h304, 32'h308, 32'h30C};
    start_refill(32'h300, 0, 4'b1101, 0);
    wait_fill(5, 0, 128'hD000030C_D0000308_D0000304_D0000300, 0, 64'h0);

    // 6: ic_miss dropped mid-FETCH does not abort the refill
    exp_q = '{32'h608, 32'h60C, 32'h600, 32'h604};
    key_base = 16'h0060;
    start_refill(32'h608, 0, 4'b1111, 1);
    tick();
    tick();
    dut_if.ic_miss = 1'b0;
    chk("drop_busy", dut_if.busy, 1);
    wait_fill(5, 1, 128'hD000060C_D0000608_D0000604_D0000600, 1, 64'h0063_0062_0061_0060);

    // 5: reset after the second beat aborts with no fill pulse
    exp_q = '{32'h500, 32'h504, 32'h508};
    start_refill(32'h500, 0, 4'b1111, 0);
    tick();
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("abort_req_valid", dut_if.mem_req_valid, 0);
    chk("abort_busy", dut_if.busy, 0);
    chk("abort_req_addr", dut_if.mem_req_addr, 0);
    chk("abort_ic_data", dut_if.ic_fill_data, 0);
    chk("abort_fill", {dut_if.ic_fill_valid, dut_if.cc_fill_valid}, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_fill", {dut_if.ic_fill_valid, dut_if.cc_fill_valid, dut_if.busy}, 0);
    end
    exp_q.delete();
`ifdef COMP_REFILL_STATS_EN
    chk("stat_rst_refills", stat_refills, 0);
    chk("stat_rst_wait", stat_mem_wait, 0);
`endif

    // 4: two wait cycles before every beat, address held while waiting
    exp_q = '{32'h404, 32'h408, 32'h40C, 32'h400};
    key_base = 16'h0040;
    start_refill(32'h404, 2, 4'b1111, 0);
    wait_fill(13, 1, 128'hD000040C_D0000408_D0000404_D0000400, 1, 64'h0043_0042_0041_0040);
`ifdef COMP_REFILL_STATS_EN
    chk("stat_refills", stat_refills, 1);
    chk("stat_comp_fills", stat_comp_fills, 1);
    chk("stat_mem_wait", stat_mem_wait, 8);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/comp_refill_ctrl.md
# comp_refill_ctrl

Line-refill engine between the fetch path, the two instruction caches (uncompressed and compressed) and instruction memory. On a miss in both caches it fetches a full line critical-word-first with wrap-around, and presents each returned word to the external dictionary lookup. It then fills either the compressed cache with one key per word or the uncompressed cache with raw words. It is the parametrised successor of the current fixed-format controller refill logic, and it adds:
- variable memory wait states with a held request,
- critical-word-first ordering,
- optional refill statistics.

## Interface
Parameters:
- NUM_BLOCKS, 4, words per line; power of two, ≥2
- BLOCK_SIZE, 4, bytes per word
- KEY_W, 16, compressed key width per word (sum of field key widths)

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- proc_valid  in  1  fetch request valid
- proc_addr  in  32  fetch byte address
- ic_miss  in  1  uncompressed cache requests refill
- cc_miss  in  1  compressed cache requests refill
- ic_fill_valid  out  1  one-cycle pulse: ic_fill_data valid
- ic_fill_data  out  32*NUM_BLOCKS  raw line, word i at bits [32*i +: 32]
- cc_fill_valid  out  1  one-cycle pulse: cc_fill_data valid
- cc_fill_data  out  KEY_W*NUM_BLOCKS  key line, word i at [KEY_W*i +: KEY_W]
- mem_req_valid  out  1  memory read request
- mem_req_ready  in  1  mem_req_rdata valid for mem_req_addr this cycle
- mem_req_addr  out  32  word-aligned read address
- mem_req_rdata  in  32  read data
- look_word  out  32  word presented to dictionaries (= mem_req_rdata, combinational)
- look_hit  in  1  all field dictionaries hit for look_word (same cycle)
- look_key  in  KEY_W  concatenated keys for look_word (same cycle)
- busy  out  1  state ≠ IDLE

## Operation
- Derived: OFF = log2(NUM_BLOCKS), BOFF = log2(BLOCK_SIZE), base = {proc_addr[31:OFF+BOFF], 0}, start = proc_addr[OFF+BOFF-1:BOFF].
- FSM states: IDLE, FETCH, FILL, DRAIN.
- IDLE: when proc_valid & ic_miss & cc_miss:
  - latch base and start;
  - ptr←start, beats←0, comp_ok←1;
  - next state FETCH.
- FETCH:
  - mem_req_valid=1, mem_req_addr = base | (ptr<<BOFF).
  - Each cycle with mem_req_ready:
    - ic buffer slot ptr ← mem_req_rdata;
    - if comp_ok & look_hit, cc buffer slot ptr ← look_key;
    - comp_ok ← comp_ok & look_hit (sticky clear);
    - ptr ← (ptr+1) mod NUM_BLOCKS;
    - beats++.
  - After the NUM_BLOCKS-th beat, next state is FILL.
- FILL (one cycle):
  - mem_req_valid=0;
  - cc_fill_valid=comp_ok, ic_fill_valid=~comp_ok (exactly one is high).
  - Fill data is the full buffer in address order.
- DRAIN: one cycle to let the caches drop their miss; then IDLE.
- Miss/proc_valid deasserting during FETCH does not abort the refill; the fill pulse is still issued.
- look_hit/look_key are ignored on cycles without mem_req_ready.
- Buffer slots are not cleared between refills; only slots written in the current refill are meaningful (all NUM_BLOCKS are always written).

## Timing
- Reset: state IDLE, mem_req_valid=0, mem_req_addr=0, ic/cc_fill_valid=0, ic/cc_fill_data=0, busy=0, internal counters 0.
- resetn low in any state → IDLE at that edge; no fill pulse is issued.
- Zero-wait memory:
  - miss seen in IDLE at cycle T;
  - mem_req_valid high T+1..T+NUM_BLOCKS;
  - fill pulse at T+NUM_BLOCKS+1;
  - DRAIN at T+NUM_BLOCKS+2;
  - IDLE (accepting) at T+NUM_BLOCKS+3.
- Each wait cycle (valid & ~ready) adds one cycle. mem_req_addr is held stable while waiting.
- mem_req_valid stays high continuously between beats; the address changes only on the cycle after a handshake.

## Configuration
- COMP_REFILL_STATS_EN: when defined, adds three output ports:
  - stat_refills (32, out): increments on every fill pulse;
  - stat_comp_fills (32, out): increments on cc_fill_valid;
  - stat_mem_wait (32, out): increments each FETCH cycle with mem_req_ready=0.
- All three saturate at 32'hFFFFFFFF and reset to 0.
- When the macro is undefined, the ports and counters are absent and behaviour is otherwise identical.

## Test plan
- Zero-wait memory, proc_addr=0x100, look_hit=1 all beats, look_key=word index+0x10:
  - mem_req_addr 0x100,0x104,0x108,0x10C;
  - cc_fill_valid pulse at T+5 with cc_fill_data={0x13,0x12,0x11,0x10};
  - ic_fill_valid stays 0.
- proc_addr=0x20C (start=3), zero wait:
  - address order 0x20C,0x200,0x204,0x208;
  - ic_fill_data slots land at address positions.
- look_hit=0 on 2nd beat only:
  - comp_ok clears;
  - ic_fill_valid pulses with all 4 raw words;
  - cc_fill_valid stays 0.
- 2 wait cycles before each beat:
  - mem_req_addr held stable across waits;
  - fill at T+13;
  - with COMP_REFILL_STATS_EN, stat_mem_wait=8, stat_refills=1.
- resetn asserted after the 2nd beat: next cycle mem_req_valid=0, busy=0, and no fill pulse.
- ic_miss dropped mid-FETCH: refill completes and the fill pulse still occurs.
